// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: NOP encoding, 2-bit branch counter states, BTB entry layout.
// Used by fetch_stage and fetch_btb; the BTB itself exists only when FETCH_BTB_EN is defined.
package pipe_pkg;

  localparam logic [31:0] NOP = 32'h2000_0000;  // addi r0,r0,0

  // Entry fields are sized for the widest PC; narrower PCs zero-extend into them.
  localparam int BTB_FIELD_W = 32;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;

  typedef struct packed {
    logic                   valid;
    logic [BTB_FIELD_W-1:0] tag;
    logic [BTB_FIELD_W-1:0] target;
    ctr_t                   ctr;
  } btb_entry_t;

  function automatic ctr_t ctr_step(input ctr_t c, input logic taken);
    ctr_t r;
    r = c;
    if (taken) begin
      if (c != CTR_ST) r = ctr_t'(c + 2'd1);
    end else begin
      if (c != CTR_SNT) r = ctr_t'(c - 2'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Signals between the fetch stage and its surroundings (EX feedback, hazard stalls,
// instruction memory and the F->D register). master = fetch stage, slave = environment.
interface fetch_stage_if #(
  parameter int XLEN    = 32,
  parameter int PC_BITS = 12
);
  logic               stall_D;
  logic               MEM_stall;
  logic               EX_taken;
  logic [PC_BITS-1:0] EX_redirect_pc;
  logic               EX_br_valid;
  logic [PC_BITS-1:0] EX_br_pc;
  logic               EX_br_taken;
  logic [PC_BITS-1:0] EX_br_target;
  logic [PC_BITS-1:0] imem_addr;
  logic [XLEN-1:0]    imem_rdata;
  logic [PC_BITS-1:0] F_pc;
  logic [XLEN-1:0]    F_inst;
  logic               F_BP_taken;
  logic [PC_BITS-1:0] F_BP_target_pc;
  logic [XLEN-1:0]    F_link_addr;

  modport master (
    input  stall_D, MEM_stall, EX_taken, EX_redirect_pc,
    input  EX_br_valid, EX_br_pc, EX_br_taken, EX_br_target,
    output imem_addr,
    input  imem_rdata,
    output F_pc, F_inst, F_BP_taken, F_BP_target_pc, F_link_addr
  );

  modport slave (
    output stall_D, MEM_stall, EX_taken, EX_redirect_pc,
    output EX_br_valid, EX_br_pc, EX_br_taken, EX_br_target,
    input  imem_addr,
    output imem_rdata,
    input  F_pc, F_inst, F_BP_taken, F_BP_target_pc, F_link_addr
  );
endinterface

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Combinational lookup; clocked update that is read-before-write against the lookup.
module fetch_btb
  import pipe_pkg::*;
#(
  parameter int PC_BITS     = 12,
  parameter int BTB_ENTRIES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_BITS-1:0] lookup_pc,
  output logic               pred_taken,
  output logic [PC_BITS-1:0] pred_target,
  input  logic               upd_en,
  input  logic [PC_BITS-1:0] upd_pc,
  input  logic               upd_taken,
  input  logic [PC_BITS-1:0] upd_target
);
  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = PC_BITS - IDX - 2;

  logic [IDX-1:0]   lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  btb_entry_t       entry_q [BTB_ENTRIES];
  btb_entry_t       lk_e, up_e;
  logic             lk_hit, up_hit;
  logic             unused_bits;

  assign lk_idx = lookup_pc[IDX+1:2];
  assign lk_tag = lookup_pc[PC_BITS-1:IDX+2];
  assign up_idx = upd_pc[IDX+1:2];
  assign up_tag = upd_pc[PC_BITS-1:IDX+2];

  assign lk_e   = entry_q[lk_idx];
  assign up_e   = entry_q[up_idx];
  assign lk_hit = lk_e.valid && (lk_e.tag == BTB_FIELD_W'(lk_tag));
  assign up_hit = up_e.valid && (up_e.tag == BTB_FIELD_W'(up_tag));

  assign pred_taken  = lk_hit && lk_e.ctr[1];
  assign pred_target = lk_e.target[PC_BITS-1:0];

  assign unused_bits = ^{lk_e.target[BTB_FIELD_W-1:PC_BITS], up_e.target, up_e.ctr, upd_pc[1:0]};

  genvar gi;
  generate
    for (gi = 0; gi < BTB_ENTRIES; gi++) begin : g_entry
      btb_entry_t entry_reg;

      // Only valid is reset; other fields are ignored until an allocation sets valid.
      always_ff @(posedge clk) begin
        if (rst) begin
          entry_reg.valid <= 1'b0;
        end else if (upd_en && (up_idx == IDX'(gi))) begin
          if (up_hit) begin
            entry_reg.ctr <= ctr_step(entry_reg.ctr, upd_taken);
            if (upd_taken) entry_reg.target <= BTB_FIELD_W'(upd_target);
          end else if (upd_taken) begin
            entry_reg.valid  <= 1'b1;
            entry_reg.tag    <= BTB_FIELD_W'(up_tag);
            entry_reg.target <= BTB_FIELD_W'(upd_target);
            entry_reg.ctr    <= CTR_WT;
          end
        end
      end

      assign entry_q[gi] = entry_reg;
    end
  endgenerate

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, async imem address, optional BTB prediction
// (enabled by defining FETCH_BTB_EN) and EX mispredict redirect; outputs feed f_to_d_reg.
module fetch_stage
  import pipe_pkg::*;
#(
  parameter int                 XLEN        = 32,
  parameter int                 PC_BITS     = 12,
  parameter logic [PC_BITS-1:0] RESET_PC    = '0,
  parameter int                 BTB_ENTRIES = 16
) (
  input logic           clk,
  input logic           rst,
  fetch_stage_if.master bus
);
  logic [PC_BITS-1:0] pc_reg;
  logic [PC_BITS-1:0] pc_next;
  logic [PC_BITS-1:0] pc_plus4;
  logic               pred_taken;
  logic [PC_BITS-1:0] pred_target;
  logic               flush;

  assign flush    = bus.EX_taken;
  assign pc_plus4 = pc_reg + PC_BITS'(4);

`ifdef FETCH_BTB_EN
  fetch_btb #(
    .PC_BITS     (PC_BITS),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk         (clk),
    .rst         (rst),
    .lookup_pc   (pc_reg),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_en      (bus.EX_br_valid && !bus.MEM_stall),
    .upd_pc      (bus.EX_br_pc),
    .upd_taken   (bus.EX_br_taken),
    .upd_target  (bus.EX_br_target)
  );
`else
  logic unused_br;
  assign unused_br   = ^{bus.EX_br_valid, bus.EX_br_pc, bus.EX_br_taken, bus.EX_br_target};
  assign pred_taken  = 1'b0;
  assign pred_target = '0;
`endif

  // A memory stall freezes everything, even a pending redirect, until it drops.
  always_comb begin
    pc_next = pc_plus4;
    if (bus.MEM_stall)     pc_next = pc_reg;
    else if (flush)        pc_next = bus.EX_redirect_pc;
    else if (bus.stall_D)  pc_next = pc_reg;
    else if (pred_taken)   pc_next = pred_target;
  end

  always_ff @(posedge clk) begin
    if (rst) pc_reg <= RESET_PC;
    else     pc_reg <= pc_next;
  end

  assign bus.imem_addr      = pc_reg;
  assign bus.F_pc           = pc_reg;
  assign bus.F_inst         = flush ? XLEN'(NOP) : bus.imem_rdata;
  assign bus.F_BP_taken     = pred_taken && !flush;
  assign bus.F_BP_target_pc = (pred_taken && !flush) ? pred_target : '0;
  assign bus.F_link_addr    = XLEN'(pc_reg) + XLEN'(4);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stalls, redirects, BTB training, PC wrap.
// Prediction checks expect BTB behaviour only when FETCH_BTB_EN is defined.
module tb_fetch_stage;
  import pipe_pkg::*;

`ifdef FETCH_BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif
  localparam logic [31:0] IMEM_TAG = 32'hA500_0000;

  logic clk;
  logic rst;
  int   checks_total  = 0;
  int   checks_passed = 0;
  int   checks_failed = 0;

  fetch_stage_if #(.XLEN(32), .PC_BITS(12)) bus ();

  fetch_stage #(
    .XLEN        (32),
    .PC_BITS     (12),
    .RESET_PC    (12'h000),
    .BTB_ENTRIES (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Instruction memory stand-in: each word encodes its own address.
  assign bus.imem_rdata = IMEM_TAG | 32'(bus.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks_total++;
    assert (obs === want) checks_passed++;
    else begin
      checks_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // Check the current fetch outputs at the falling edge, then advance one clock.
  task automatic expect_cycle(input logic [11:0] pc, input logic taken,
                              input logic [11:0] tgt, input logic nop);
    @(negedge clk);
    $display("pc=%h inst=%h bp=%b tgt=%h link=%h", bus.F_pc, bus.F_inst,
             bus.F_BP_taken, bus.F_BP_target_pc, bus.F_link_addr);
    chk("F_pc", 32'(bus.F_pc), 32'(pc));
    chk("imem_addr", 32'(bus.imem_addr), 32'(pc));
    chk("F_inst", bus.F_inst, nop ? NOP : (IMEM_TAG | 32'(pc)));
    chk("F_BP_taken", 32'(bus.F_BP_taken), 32'(taken));
    chk("F_BP_target_pc", 32'(bus.F_BP_target_pc), 32'(tgt));
    chk("F_link_addr", bus.F_link_addr, 32'(pc) + 32'd4);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [11:0] after_br;
    rst                = 1'b1;
    bus.stall_D        = 1'b0;
    bus.MEM_stall      = 1'b0;
    bus.EX_taken       = 1'b0;
    bus.EX_redirect_pc = '0;
    bus.EX_br_valid    = 1'b0;
    bus.EX_br_pc       = '0;
    bus.EX_br_taken    = 1'b0;
    bus.EX_br_target   = '0;

    // Reset for two edges, then sequential fetch
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    expect_cycle(12'h000, 1'b0, 12'h000, 1'b0);
    expect_cycle(12'h004, 1'b0, 12'h000, 1'b0);
    expect_cycle(12'h008, 1'b0, 12'h000, 1'b0);
    expect_cycle(12'h00C, 1'b0, 12'h000, 1'b0);

    // Decode stall holds PC
    bus.stall_D = 1'b1;
    repeat (3) expect_cycle(12'h010, 1'b0, 12'h000, 1'b0);
    bus.stall_D = 1'b0;

    // Memory stall holds PC and blocks a BTB update on the current PC
    bus.MEM_stall    = 1'b1;
    bus.EX_br_valid  = 1'b1;
    bus.EX_br_pc     = 12'h010;
    bus.EX_br_taken  = 1'b1;
    bus.EX_br_target = 12'h300;
    repeat (3) expect_cycle(12'h010, 1'b0, 12'h000, 1'b0);
    bus.MEM_stall   = 1'b0;
    bus.EX_br_valid = 1'b0;
    expect_cycle(12'h010, 1'b0, 12'h000, 1'b0);

    // Mispredict redirect kills the fetched instruction
    bus.EX_taken       = 1'b1;
    bus.EX_redirect_pc = 12'h200;
    expect_cycle(12'h014, 1'b0, 12'h000, 1'b1);
    bus.EX_taken = 1'b0;

    // Train 0x040 taken to 0x100
    bus.EX_br_valid  = 1'b1;
    bus.EX_br_pc     = 12'h040;
    bus.EX_br_taken  = 1'b1;
    bus.EX_br_target = 12'h100;
    expect_cycle(12'h200, 1'b0, 12'h000, 1'b0);
    bus.EX_br_valid    = 1'b0;
    bus.EX_taken       = 1'b1;
    bus.EX_redirect_pc = 12'h040;
    expect_cycle(12'h204, 1'b0, 12'h000, 1'b1);
    bus.EX_taken = 1'b0;
    after_br = BTB_ON ? 12'h100 : 12'h044;
    expect_cycle(12'h040, BTB_ON, BTB_ON ? 12'h100 : 12'h000, 1'b0);

    // Two not-taken updates drop the counter below the taken threshold
    bus.EX_br_valid = 1'b1;
    bus.EX_br_pc    = 12'h040;
    bus.EX_br_taken = 1'b0;
    expect_cycle(after_br, 1'b0, 12'h000, 1'b0);
    expect_cycle(after_br + 12'h004, 1'b0, 12'h000, 1'b0);
    bus.EX_br_valid    = 1'b0;
    bus.EX_taken       = 1'b1;
    bus.EX_redirect_pc = 12'h040;
    expect_cycle(after_br + 12'h008, 1'b0, 12'h000, 1'b1);
    bus.EX_taken = 1'b0;
    expect_cycle(12'h040, 1'b0, 12'h000, 1'b0);

    // PC wrap at the top of the address space
    bus.EX_taken       = 1'b1;
    bus.EX_redirect_pc = 12'hFFC;
    expect_cycle(12'h044, 1'b0, 12'h000, 1'b1);
    bus.EX_taken = 1'b0;
    expect_cycle(12'hFFC, 1'b0, 12'h000, 1'b0);
    expect_cycle(12'h000, 1'b0, 12'h000, 1'b0);

    // Memory stall together with a redirect: PC holds, redirect lands once the stall drops
    bus.MEM_stall      = 1'b1;
    bus.EX_taken       = 1'b1;
    bus.EX_redirect_pc = 12'h300;
    bus.EX_br_valid    = 1'b1;
    bus.EX_br_pc       = 12'h004;
    bus.EX_br_taken    = 1'b1;
    bus.EX_br_target   = 12'h080;
    expect_cycle(12'h004, 1'b0, 12'h000, 1'b1);
    bus.MEM_stall   = 1'b0;
    bus.EX_br_valid = 1'b0;
    expect_cycle(12'h004, 1'b0, 12'h000, 1'b1);
    bus.EX_taken = 1'b0;
    expect_cycle(12'h300, 1'b0, 12'h000, 1'b0);
    bus.EX_taken       = 1'b1;
    bus.EX_redirect_pc = 12'h004;
    expect_cycle(12'h304, 1'b0, 12'h000, 1'b1);
    bus.EX_taken = 1'b0;
    expect_cycle(12'h004, 1'b0, 12'h000, 1'b0);
    expect_cycle(12'h008, 1'b0, 12'h000, 1'b0);

    // Reset mid-operation wins over a redirect
    rst                = 1'b1;
    bus.EX_taken       = 1'b1;
    bus.EX_redirect_pc = 12'h500;
    expect_cycle(12'h00C, 1'b0, 12'h000, 1'b1);
    rst          = 1'b0;
    bus.EX_taken = 1'b0;
    expect_cycle(12'h000, 1'b0, 12'h000, 1'b0);
    expect_cycle(12'h004, 1'b0, 12'h000, 1'b0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
